// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter. It re-arbitrates only at legal transfer boundaries
// and provides address-phase and data-phase owner indices for the bus muxes.
module ahb_arbiter #(
    parameter int unsigned HMST_NUM     = 4,
    parameter int unsigned HBURST_WIDTH = 3,
    parameter int unsigned MST_IDX_W    = $clog2(HMST_NUM)
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic [HMST_NUM-1:0]     hbusreq_i,
    input  logic [HMST_NUM-1:0]     hlock_i,
    input  logic [1:0]              htrans_i,
    input  logic [HBURST_WIDTH-1:0] hburst_i,
    input  logic                    hready_i,
    output logic [HMST_NUM-1:0]     hgrant_o,
    output logic [MST_IDX_W-1:0]    grant_o,
    output logic [MST_IDX_W-1:0]    grant_d_o,
    output logic                    hmastlock_o
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BU_SINGLE = 3'd0,
        BU_INCR   = 3'd1,
        BU_WRAP4  = 3'd2,
        BU_INCR4  = 3'd3,
        BU_WRAP8  = 3'd4,
        BU_INCR8  = 3'd5,
        BU_WRAP16 = 3'd6,
        BU_INCR16 = 3'd7
    } hburst_e;

    htrans_e                trans;
    hburst_e                burst;
    logic [4:0]             rem_q, rem_d, rem_load;
    logic [MST_IDX_W-1:0]   grant_q, grant_d;
    logic [MST_IDX_W-1:0]   grant_dp_q, grant_dp_d;
    logic [HMST_NUM-1:0]    hgrant_q, hgrant_d;
    logic                   mlock_q, mlock_d;
    logic [MST_IDX_W-1:0]   winner;
    logic                   boundary;
    logic                   arb_ok;

    assign trans = htrans_e'(htrans_i);
    assign burst = hburst_e'(hburst_i[2:0]);

    // Undefined INCR has zero beats, so beats-1 wraps to 31.
    always_comb begin
        rem_load = 5'd0;
        case (burst)
            BU_SINGLE:           rem_load = 5'd0;
            BU_INCR:             rem_load = 5'd31;
            BU_WRAP4,  BU_INCR4:  rem_load = 5'd3;
            BU_WRAP8,  BU_INCR8:  rem_load = 5'd7;
            BU_WRAP16, BU_INCR16: rem_load = 5'd15;
            default:             rem_load = 5'd0;
        endcase
    end

    always_comb begin
        rem_d = rem_q;
        if (hready_i) begin
            if (trans == TR_NONSEQ) begin
                rem_d = rem_load;
            end else if (trans == TR_SEQ) begin
                rem_d = rem_q - 5'd1;
            end
        end
    end

    always_comb begin
        boundary = (trans == TR_IDLE)
                || (trans == TR_NONSEQ && burst == BU_SINGLE)
                || (trans == TR_SEQ && rem_q == 5'd1)
                || (burst == BU_INCR && !hbusreq_i[grant_q]);
        arb_ok   = hready_i && !hlock_i[grant_q] && boundary;
    end

    // Search starts after the current owner and ends on it; park on master 0 if idle.
    always_comb begin : pick
        int unsigned          idx;
        logic [MST_IDX_W-1:0] idx_w;
        logic                 found;
        idx    = 0;
        idx_w  = '0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= HMST_NUM; k++) begin
            idx = 32'(grant_q) + k;
            if (idx >= HMST_NUM) begin
                idx = idx - HMST_NUM;
            end
            idx_w = MST_IDX_W'(idx);
            if (!found && hbusreq_i[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    always_comb begin
        grant_d    = grant_q;
        hgrant_d   = hgrant_q;
        grant_dp_d = grant_dp_q;
        mlock_d    = mlock_q;
        if (arb_ok) begin
            grant_d          = winner;
            hgrant_d         = '0;
            hgrant_d[winner] = 1'b1;
            mlock_d          = hlock_i[winner];
        end else if (hready_i) begin
            mlock_d = hlock_i[grant_q];
        end
        if (hready_i) begin
            grant_dp_d = grant_q;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rem_q      <= '0;
            grant_q    <= '0;
            hgrant_q   <= HMST_NUM'(1);
            grant_dp_q <= '0;
            mlock_q    <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            grant_q    <= grant_d;
            hgrant_q   <= hgrant_d;
            grant_dp_q <= grant_dp_d;
            mlock_q    <= mlock_d;
        end
    end

    assign hgrant_o    = hgrant_q;
    assign grant_o     = grant_q;
    assign grant_d_o   = grant_dp_q;
    assign hmastlock_o = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_ahb_arbiter;

    localparam int N = 4;

    logic         hclk = 1'b0;
    logic         hresetn;
    logic [N-1:0] req, lock;
    logic [1:0]   trans;
    logic [2:0]   burst;
    logic         ready;
    logic [N-1:0] hgrant;
    logic [1:0]   grant, grant_d;
    logic         mlock;

    int m_own, m_dgr, m_rem;
    bit m_lock;
    int n_checks = 0;
    int n_pass   = 0;

    ahb_arbiter #(.HMST_NUM(N), .HBURST_WIDTH(3)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hbusreq_i   (req),
        .hlock_i     (lock),
        .htrans_i    (trans),
        .hburst_i    (burst),
        .hready_i    (ready),
        .hgrant_o    (hgrant),
        .grant_o     (grant),
        .grant_d_o   (grant_d),
        .hmastlock_o (mlock)
    );

    initial forever #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int beats(input int b);
        case (b)
            0:       return 1;
            1:       return 0;
            2, 3:    return 4;
            4, 5:    return 8;
            default: return 16;
        endcase
    endfunction

    task automatic model_reset();
        m_own = 0; m_dgr = 0; m_rem = 0; m_lock = 0;
    endtask

    task automatic check_model();
        check("grant",    grant,   m_own);
        check("hgrant",   hgrant,  32'(1) << m_own);
        check("grant_d",  grant_d, m_dgr);
        check("mastlock", mlock,   m_lock);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                        input int t, input int b, input bit rdy);
        bit arb, found, n_lock;
        int win, n_dgr, n_rem, c;
        req = r; lock = l; trans = 2'(t); burst = 3'(b); ready = rdy;
        arb = rdy && !l[m_own] && (t == 0 || (t == 2 && b == 0) ||
                                   (t == 3 && m_rem == 1) || (b == 1 && !r[m_own]));
        win = m_own;
        if (arb) begin
            win = 0; found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_own + k) % N;
                if (!found && r[c]) begin win = c; found = 1; end
            end
        end
        n_lock = arb ? l[win] : (rdy ? l[m_own] : m_lock);
        n_dgr  = rdy ? m_own : m_dgr;
        n_rem  = m_rem;
        if (rdy && t == 2) n_rem = (beats(b) - 1) & 31;
        if (rdy && t == 3) n_rem = (m_rem - 1) & 31;
        @(posedge hclk);
        #1;
        m_own = win; m_dgr = n_dgr; m_rem = n_rem; m_lock = n_lock;
        check_model();
    endtask

    // Asserted between edges so the clear must be asynchronous to be seen.
    task automatic do_reset();
        #2;
        hresetn = 1'b0;
        #1;
        model_reset();
        check("rst_hgrant", hgrant, 1);
        check("rst_grant",  grant,  0);
        check_model();
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
    endtask

    initial begin
        int rr_exp [4] = '{1, 3, 1, 3};
        int prev;
        hresetn = 1'b0;
        req = 4'b1111; lock = '0; trans = 2'd0; burst = 3'd0; ready = 1'b1;
        model_reset();
        @(posedge hclk);
        #1;
        check("rst_hgrant", hgrant, 4'b0001);
        check("rst_grant",  grant,  0);
        check("rst_grantd", grant_d, 0);
        check("rst_lock",   mlock,  0);
        hresetn = 1'b1;
        step(4'b1111, '0, 0, 0, 1);
        check("rst_release", grant, 1);

        // Round robin between masters 1 and 3
        do_reset();
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            step(4'b1010, '0, 2, 0, 1);
            check("rr_grant", grant, rr_exp[i]);
            check("rr_lag", grant_d, prev);
            prev = rr_exp[i];
        end

        // INCR4 by master 2 with master 0 waiting
        do_reset();
        step(4'b0101, '0, 0, 0, 1);
        check("incr4_own", grant, 2);
        step(4'b0101, '0, 2, 3, 1);
        check("incr4_b0", grant, 2);
        for (int i = 0; i < 2; i++) begin
            step(4'b0101, '0, 3, 3, 1);
            check("incr4_mid", grant, 2);
        end
        step(4'b0101, '0, 3, 3, 1);
        check("incr4_end", grant, 0);

        // Wait states on the last beat of INCR8
        do_reset();
        step(4'b0010, '0, 0, 0, 1);
        step(4'b0011, '0, 2, 5, 1);
        for (int i = 0; i < 6; i++) step(4'b0011, '0, 3, 5, 1);
        check("incr8_own", grant, 1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, '0, 3, 5, 0);
            check("wait_hold", grant, 1);
        end
        step(4'b0011, '0, 3, 5, 1);
        check("wait_end", grant, 0);

        // Locked master 1 across two INCR4 bursts
        do_reset();
        step(4'b0010, 4'b0010, 0, 0, 1);
        check("lock_own", grant, 1);
        check("lock_ml", mlock, 1);
        for (int j = 0; j < 2; j++) begin
            step(4'b0110, 4'b0010, 2, 3, 1);
            for (int i = 0; i < 3; i++) step(4'b0110, 4'b0010, 3, 3, 1);
            check("lock_keep", grant, 1);
            check("lock_keep_ml", mlock, 1);
        end
        step(4'b0110, '0, 2, 0, 1);
        check("unlock_grant", grant, 2);
        check("unlock_ml", mlock, 0);

        // Undefined INCR released by master 3, then reset mid-burst
        do_reset();
        step(4'b1000, '0, 0, 0, 1);
        check("incr_own", grant, 3);
        step(4'b1000, '0, 2, 1, 1);
        step(4'b1000, '0, 3, 1, 1);
        step(4'b1000, '0, 3, 1, 1);
        check("incr_keep", grant, 3);
        step(4'b0000, '0, 3, 1, 1);
        check("incr_park", grant, 0);
        step(4'b1000, '0, 0, 0, 1);
        step(4'b1000, '0, 2, 3, 1);
        step(4'b1000, '0, 3, 3, 1);
        check("midrst_own", grant, 3);
        do_reset();
        step(4'b0000, '0, 0, 0, 1);
        check("midrst_park", grant, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(N'($urandom), N'($urandom & $urandom & $urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                     $urandom_range(0, 3) != 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
